// File: rtl/rv_pkg.sv
// Shared RISC-V constants: datapath width and load funct3 encodings.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks byte/half/word from the raw memory word,
// extends it, and flags misaligned or reserved-size loads.
module load_align
    import rv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addrLow,
    input  logic [XLEN-1:0] loadData,
    output logic [XLEN-1:0] loadValue_c,
    output logic            loadFault_c
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal = loadData[7:0];
        case (addrLow)
            2'd0: byteVal = loadData[7:0];
            2'd1: byteVal = loadData[15:8];
            2'd2: byteVal = loadData[23:16];
            2'd3: byteVal = loadData[31:24];
            default: byteVal = loadData[7:0];
        endcase
        halfVal = addrLow[1] ? loadData[31:16] : loadData[15:0];
    end

    always_comb begin
        loadValue_c = '0;
        loadFault_c = 1'b0;
        case (funct3)
            F3_LB:  loadValue_c = {{24{byteVal[7]}}, byteVal};
            F3_LBU: loadValue_c = {24'd0, byteVal};
            F3_LH: begin
                loadValue_c = {{16{halfVal[15]}}, halfVal};
                loadFault_c = addrLow[0];
            end
            F3_LHU: begin
                loadValue_c = {16'd0, halfVal};
                loadFault_c = addrLow[0];
            end
            F3_LW: begin
                loadValue_c = loadData;
                loadFault_c = (addrLow != 2'd0);
            end
            default: loadFault_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline register: captures the extracted MEM result, drives the
// register-file write port, and counts retired instructions.
module wb_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemValid,
    input  logic            MemRegWrite,
    input  logic            MemToReg,
    input  logic [2:0]      MemFunct3,
    input  logic [1:0]      MemAddrLow,
    input  logic [XLEN-1:0] MemAluResult,
    input  logic [XLEN-1:0] MemLoadData,
    input  logic [4:0]      MemRd,
    input  logic            Stall,
    input  logic            Flush,
    output logic [XLEN-1:0] WriteData,
    output logic [4:0]      WriteAddress,
    output logic            RegWriteEn,
    output logic            WbValid,
    output logic            InstRetired,
    output logic            LoadFault,
    output logic [31:0]     RetireCount
);

    import rv_pkg::*;

    logic [XLEN-1:0] loadValue_c;
    logic            loadFault_c;
    logic            fault_c;
    logic [XLEN-1:0] result_c;
    logic            writeEn_c;

    load_align u_loadAlign (
        .funct3      (MemFunct3),
        .addrLow     (MemAddrLow),
        .loadData    (MemLoadData),
        .loadValue_c (loadValue_c),
        .loadFault_c (loadFault_c)
    );

    // Extraction happens before the register so WB data lags MEM by one cycle.
    always_comb begin
        fault_c   = MemToReg & loadFault_c;
        result_c  = MemToReg ? loadValue_c : MemAluResult;
        writeEn_c = MemValid & MemRegWrite & (MemRd != 5'd0) & ~fault_c;
    end

    // Stall holds the payload and write enable so a repeated write is harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WbValid      <= 1'b0;
            RegWriteEn   <= 1'b0;
            InstRetired  <= 1'b0;
            LoadFault    <= 1'b0;
            WriteData    <= '0;
            WriteAddress <= '0;
            RetireCount  <= '0;
        end else if (Flush) begin
            WbValid     <= 1'b0;
            RegWriteEn  <= 1'b0;
            InstRetired <= 1'b0;
            LoadFault   <= 1'b0;
        end else if (Stall) begin
            InstRetired <= 1'b0;
            LoadFault   <= 1'b0;
        end else begin
            WbValid      <= MemValid;
            RegWriteEn   <= writeEn_c;
            InstRetired  <= MemValid;
            LoadFault    <= MemValid & fault_c;
            WriteData    <= result_c;
            WriteAddress <= MemRd;
            if (MemValid) begin
                RetireCount <= RetireCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors, stall/flush/reset
// sequences and randomized traffic against a behavioural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemValid, MemRegWrite, MemToReg;
    logic [2:0]  MemFunct3;
    logic [1:0]  MemAddrLow;
    logic [31:0] MemAluResult, MemLoadData;
    logic [4:0]  MemRd;
    logic        Stall, Flush;
    logic [31:0] WriteData;
    logic [4:0]  WriteAddress;
    logic        RegWriteEn, WbValid, InstRetired, LoadFault;
    logic [31:0] RetireCount;

    int tests = 0;
    int failed = 0;

    wb_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemValid(MemValid), .MemRegWrite(MemRegWrite), .MemToReg(MemToReg),
        .MemFunct3(MemFunct3), .MemAddrLow(MemAddrLow),
        .MemAluResult(MemAluResult), .MemLoadData(MemLoadData), .MemRd(MemRd),
        .Stall(Stall), .Flush(Flush),
        .WriteData(WriteData), .WriteAddress(WriteAddress),
        .RegWriteEn(RegWriteEn), .WbValid(WbValid), .InstRetired(InstRetired),
        .LoadFault(LoadFault), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rw, toReg;
        logic [2:0]  f3;
        logic [1:0]  addr;
        logic [31:0] alu, load;
        logic [4:0]  rd;
        logic [31:0] expData;
        logic        expWe, expFault;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic tr, input logic [2:0] f3,
                         input logic [1:0] a, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [4:0] rd);
        MemValid = v; MemRegWrite = rw; MemToReg = tr; MemFunct3 = f3;
        MemAddrLow = a; MemAluResult = alu; MemLoadData = ld; MemRd = rd;
    endtask

    // Reference load semantics computed with shifts and masks.
    function automatic void modelLoad(input logic [2:0] f3, input int a, input logic [31:0] w,
                                      output logic [31:0] val, output logic flt);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        val = 32'd0;
        flt = 1'b0;
        case (f3)
            3'd0: val = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd4: val = b;
            3'd1: begin val = (h >= 32'h8000) ? h + 32'hFFFF_0000 : h; flt = (a % 2) != 0; end
            3'd5: begin val = h; flt = (a % 2) != 0; end
            3'd2: begin val = w; flt = (a != 0); end
            default: flt = 1'b1;
        endcase
    endfunction

    vec_t vecs[$];
    logic [31:0] expCnt;

    // model state for random phase
    logic        mValid, mWe, mRet, mFault;
    logic [31:0] mData, mCnt;
    logic [4:0]  mAddr;

    initial begin
        rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd0);
        step(); step();
        chk("rst_WbValid", {31'd0, WbValid}, 32'd0);
        chk("rst_RegWriteEn", {31'd0, RegWriteEn}, 32'd0);
        chk("rst_InstRetired", {31'd0, InstRetired}, 32'd0);
        chk("rst_LoadFault", {31'd0, LoadFault}, 32'd0);
        chk("rst_WriteData", WriteData, 32'd0);
        chk("rst_WriteAddress", {27'd0, WriteAddress}, 32'd0);
        chk("rst_RetireCount", RetireCount, 32'd0);
        rst_n = 1'b1;

        // valid rw toReg f3 addr alu load rd expData expWe expFault
        vecs.push_back('{1, 1, 0, 3'd0, 2'd0, 32'h12345678, 32'h0, 5'd5, 32'h12345678, 1, 0});
        vecs.push_back('{1, 1, 1, 3'd0, 2'd3, 32'h0, 32'h80FF0011, 5'd6, 32'hFFFFFF80, 1, 0});
        vecs.push_back('{1, 1, 1, 3'd4, 2'd3, 32'h0, 32'h80FF0011, 5'd6, 32'h00000080, 1, 0});
        vecs.push_back('{1, 1, 1, 3'd5, 2'd2, 32'h0, 32'h80FF0011, 5'd7, 32'h000080FF, 1, 0});
        vecs.push_back('{1, 1, 1, 3'd1, 2'd2, 32'h0, 32'h80FF0011, 5'd8, 32'hFFFF80FF, 1, 0});
        vecs.push_back('{1, 1, 1, 3'd0, 2'd0, 32'h0, 32'h80FF0011, 5'd9, 32'h00000011, 1, 0});
        vecs.push_back('{1, 1, 1, 3'd0, 2'd2, 32'h0, 32'h80FF0011, 5'd9, 32'hFFFFFFFF, 1, 0});
        vecs.push_back('{1, 1, 1, 3'd1, 2'd0, 32'h0, 32'h80FF0011, 5'd9, 32'h00000011, 1, 0});
        vecs.push_back('{1, 1, 1, 3'd2, 2'd0, 32'h0, 32'h80FF0011, 5'd31, 32'h80FF0011, 1, 0});
        vecs.push_back('{1, 1, 1, 3'd2, 2'd2, 32'h0, 32'h80FF0011, 5'd10, 32'h0, 0, 1});
        vecs.push_back('{1, 1, 1, 3'd1, 2'd1, 32'h0, 32'h80FF0011, 5'd10, 32'h0, 0, 1});
        vecs.push_back('{1, 1, 1, 3'd5, 2'd3, 32'h0, 32'h80FF0011, 5'd10, 32'h0, 0, 1});
        vecs.push_back('{1, 1, 1, 3'd3, 2'd0, 32'h0, 32'h80FF0011, 5'd10, 32'h0, 0, 1});
        vecs.push_back('{1, 1, 1, 3'd6, 2'd0, 32'h0, 32'h80FF0011, 5'd10, 32'h0, 0, 1});
        vecs.push_back('{1, 1, 1, 3'd7, 2'd0, 32'h0, 32'h80FF0011, 5'd10, 32'h0, 0, 1});
        vecs.push_back('{1, 1, 0, 3'd7, 2'd1, 32'hCAFEF00D, 32'h0, 5'd11, 32'hCAFEF00D, 1, 0});
        vecs.push_back('{1, 1, 0, 3'd0, 2'd0, 32'h55AA55AA, 32'h0, 5'd0, 32'h0, 0, 0});
        vecs.push_back('{1, 0, 0, 3'd0, 2'd0, 32'h55AA55AA, 32'h0, 5'd12, 32'h0, 0, 0});
        vecs.push_back('{0, 1, 0, 3'd0, 2'd0, 32'h55AA55AA, 32'h0, 5'd13, 32'h0, 0, 0});

        expCnt = 32'd0;
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].rw, vecs[i].toReg, vecs[i].f3, vecs[i].addr,
                  vecs[i].alu, vecs[i].load, vecs[i].rd);
            step();
            if (vecs[i].valid) expCnt = expCnt + 32'd1;
            chk($sformatf("v%0d_RegWriteEn", i), {31'd0, RegWriteEn}, {31'd0, vecs[i].expWe});
            chk($sformatf("v%0d_LoadFault", i), {31'd0, LoadFault}, {31'd0, vecs[i].expFault});
            chk($sformatf("v%0d_InstRetired", i), {31'd0, InstRetired}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d_WbValid", i), {31'd0, WbValid}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d_RetireCount", i), RetireCount, expCnt);
            if (vecs[i].valid)
                chk($sformatf("v%0d_WriteAddress", i), {27'd0, WriteAddress}, {27'd0, vecs[i].rd});
            if (vecs[i].expWe)
                chk($sformatf("v%0d_WriteData", i), WriteData, vecs[i].expData);
        end

        // Stall hold: outputs frozen, write stays asserted, retire pulses once.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hA5A5_0001, 32'h0, 5'd7);
        step();
        expCnt = expCnt + 32'd1;
        chk("stall_first_ret", {31'd0, InstRetired}, 32'd1);
        Stall = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'd2, 2'd1, 32'hDEAD_BEEF, 32'h1111_2222, 5'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_WriteData", WriteData, 32'hA5A5_0001);
            chk("stall_WriteAddress", {27'd0, WriteAddress}, 32'd7);
            chk("stall_RegWriteEn", {31'd0, RegWriteEn}, 32'd1);
            chk("stall_InstRetired", {31'd0, InstRetired}, 32'd0);
            chk("stall_LoadFault", {31'd0, LoadFault}, 32'd0);
            chk("stall_RetireCount", RetireCount, expCnt);
        end
        Flush = 1'b1;
        step();
        chk("flush_WbValid", {31'd0, WbValid}, 32'd0);
        chk("flush_RegWriteEn", {31'd0, RegWriteEn}, 32'd0);
        chk("flush_RetireCount", RetireCount, expCnt);
        Flush = 1'b0; Stall = 1'b0;

        // Counter wrap.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        force dut.RetireCount = 32'hFFFF_FFFF;
        #1;
        release dut.RetireCount;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1, 32'h0, 5'd1);
        step();
        chk("wrap_RetireCount", RetireCount, 32'd0);
        chk("wrap_InstRetired", {31'd0, InstRetired}, 32'd1);

        // Reset in the middle of a stall discards the held instruction.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h0, 5'd9);
        step();
        Stall = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        chk("rststall_WbValid", {31'd0, WbValid}, 32'd0);
        chk("rststall_RegWriteEn", {31'd0, RegWriteEn}, 32'd0);
        chk("rststall_WriteData", WriteData, 32'd0);
        chk("rststall_WriteAddress", {27'd0, WriteAddress}, 32'd0);
        chk("rststall_RetireCount", RetireCount, 32'd0);
        chk("rststall_InstRetired", {31'd0, InstRetired}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
        step();
        chk("postrst_RegWriteEn", {31'd0, RegWriteEn}, 32'd0);

        // Random traffic against the model; starts from the empty post-reset state.
        mValid = 1'b0; mWe = 1'b0; mRet = 1'b0; mFault = 1'b0;
        mData = 32'd0; mAddr = 5'd0; mCnt = 32'd0;
        for (int n = 0; n < 500; n++) begin
            logic [31:0] val;
            logic flt;
            drive(($urandom_range(0, 9) < 8), 1'($urandom), 1'($urandom), 3'($urandom),
                  2'($urandom), $urandom, $urandom, 5'($urandom));
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            modelLoad(MemFunct3, int'(MemAddrLow), MemLoadData, val, flt);
            flt = flt & MemToReg;
            if (Flush) begin
                mValid = 1'b0; mWe = 1'b0; mRet = 1'b0; mFault = 1'b0;
            end else if (Stall) begin
                mRet = 1'b0; mFault = 1'b0;
            end else begin
                mValid = MemValid;
                mRet = MemValid;
                mFault = MemValid & flt;
                mWe = MemValid & MemRegWrite & (MemRd != 5'd0) & !flt;
                mData = MemToReg ? val : MemAluResult;
                mAddr = MemRd;
                if (MemValid) mCnt = mCnt + 32'd1;
            end
            step();
            chk("rnd_WbValid", {31'd0, WbValid}, {31'd0, mValid});
            chk("rnd_RegWriteEn", {31'd0, RegWriteEn}, {31'd0, mWe});
            chk("rnd_InstRetired", {31'd0, InstRetired}, {31'd0, mRet});
            chk("rnd_LoadFault", {31'd0, LoadFault}, {31'd0, mFault});
            chk("rnd_RetireCount", RetireCount, mCnt);
            if (mValid) chk("rnd_WriteAddress", {27'd0, WriteAddress}, {27'd0, mAddr});
            if (mWe) chk("rnd_WriteData", WriteData, mData);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-002 The block SHALL have one clock and one reset: the clock is synchronous to all logic, and the reset is synchronous and active-low.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 MemValid  in  1  MEM stage holds a valid instruction.
REQ-006 MemRegWrite  in  1  instruction writes rd.
REQ-007 MemToReg  in  1  1 = load data to rd, 0 = ALU result to rd.
REQ-008 MemFunct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 MemAddrLow  in  2  byte offset of the load address.
REQ-010 MemAluResult  in  32  ALU result.
REQ-011 MemLoadData  in  32  raw aligned word from data memory.
REQ-012 MemRd  in  5  destination register index.
REQ-013 Stall  in  1  hold WB contents.
REQ-014 Flush  in  1  kill the incoming instruction.
REQ-015 WriteData  out  32  register-file write data.
REQ-016 WriteAddress  out  5  register-file write index.
REQ-017 RegWriteEn  out  1  register-file write enable.
REQ-018 WbValid  out  1  WB holds a valid instruction.
REQ-019 InstRetired  out  1  one-cycle pulse per instruction entering WB.
REQ-020 LoadFault  out  1  one-cycle pulse for a misaligned or reserved-size load.
REQ-021 RetireCount  out  32  count of retired instructions.

Function
REQ-022 WB state SHALL be one pipeline register, updated only on the rising clk edge, with priority rst_n, then Flush, then Stall, then capture.
REQ-023 Flush SHALL clear WbValid at the next edge even when Stall=1; the other payload fields are don't-care.
REQ-024 Stall=1 with Flush=0 SHALL hold every payload field and WbValid unchanged, and SHALL drive InstRetired=0 and LoadFault=0.
REQ-025 Capture SHALL load WbValid=MemValid and register the already-extracted result, so the latency from the MEM inputs to WriteData is exactly 1 cycle.
REQ-026 Load extraction (MemToReg=1) SHALL work as follows: byte = MemLoadData[8*MemAddrLow +: 8], half = MemLoadData[16*MemAddrLow[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, and LW passes the word through.
REQ-027 A misaligned load (LH/LHU with MemAddrLow[0]=1, or LW with MemAddrLow!=0) or a reserved MemFunct3 (011, 110, 111) with MemToReg=1 SHALL suppress the write and pulse LoadFault for the capture cycle.
REQ-028 RegWriteEn SHALL equal WbValid & RegWrite & (Rd!=0) & !fault; a write to x0 is never issued.
REQ-029 During Stall, RegWriteEn SHALL stay asserted if it was set, so the write is idempotent.
REQ-030 Outputs SHALL change only on the rising edge, so that the write port, which samples on the falling edge, sees stable data in the same cycle.
REQ-031 InstRetired SHALL pulse high for exactly the one cycle after a valid, unflushed instruction is captured, and SHALL never re-pulse while that instruction is held.
REQ-032 RetireCount SHALL increment by 1 on the same edge that sets InstRetired, wrapping from 0xFFFFFFFF to 0 with no flag.
REQ-033 A faulting load SHALL still retire (InstRetired=1, counted).

Reset
REQ-034 While rst_n=0 at an edge, the block SHALL set WbValid=0, RegWriteEn=0, InstRetired=0, LoadFault=0, WriteData=0, WriteAddress=0 and RetireCount=0.
REQ-035 Reset asserted mid-stall SHALL discard the held instruction, with no write in the following cycle.

Structure
REQ-036 Load funct3 encodings and XLEN SHALL live in the shared package rv_pkg.
REQ-037 Byte/half extraction and fault detection SHALL be one combinational sub-module, load_align.
REQ-038 RetireCount SHALL be an in-block counter.

Verification
REQ-039 ALU op, MemRd=5, MemAluResult=0x12345678 -> next cycle WriteAddress=5, WriteData=0x12345678, RegWriteEn=1, InstRetired=1, RetireCount=1.
REQ-040 LB, MemAddrLow=3, MemLoadData=0x80FF0011 -> WriteData=0xFFFFFF80; same word with LBU -> 0x00000080; LHU with MemAddrLow=2 -> 0x000080FF.
REQ-041 LW with MemAddrLow=2 -> RegWriteEn=0, LoadFault pulses 1 cycle, InstRetired=1; LH with MemAddrLow=1 gives the same response.
REQ-042 Write to MemRd=0 -> RegWriteEn=0, InstRetired=1, RetireCount increments.
REQ-043 Capture a valid op, hold Stall=1 for 3 cycles -> outputs constant, RegWriteEn=1 throughout, InstRetired high only in the first cycle; Flush=1 with Stall=1 -> WbValid=0 next cycle.
REQ-044 Preload RetireCount=0xFFFFFFFF (force), retire one -> RetireCount=0; rst_n=0 mid-stall -> all outputs 0 next cycle.
